// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode constants and fetch state encoding
package cpu_defs;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetcher_predecode.sv
// rtl/inst_fetcher_predecode.sv - static next-pc prediction (JAL and branches taken)
module fetch_predecode
  import cpu_defs::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;

  always_comb begin
    imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    case (inst[6:0])
      OPC_JAL:    next_pc = pc + imm_j;
      OPC_BRANCH: next_pc = pc + imm_b;
      default:    next_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - byte-serial instruction fetch feeding the issue queue
module inst_fetcher
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  _clear,
  input  logic [31:0]           _clear_pc,
  input  logic                  _InstFetcher_need_inst,
  output logic [31:0]           _inst_out,
  output logic                  _inst_ready_out,
  output logic [31:0]           _inst_addr,
  output logic                  _mem_req,
  output logic [ADDR_WIDTH-1:0] _mem_a,
  input  logic                  _mem_grant,
  input  logic [7:0]            _mem_din
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [2:0]            byte_cnt;
  logic [31:0]           word_buf;
  logic                  pend_valid;
  logic [1:0]            pend_idx;
  logic                  drop;
  logic [31:0]           next_pc;
  logic                  deliver;

  fetch_predecode u_predecode (
    .inst    (word_buf),
    .pc      (32'(pc)),
    .next_pc (next_pc)
  );

  assign _mem_req = rdy_in && (state == FETCH) && !byte_cnt[2];
  assign _mem_a   = (state == FETCH) ? pc + ADDR_WIDTH'(byte_cnt) : '0;

  // Delivery is combinational on need_inst so the strobe can never outrun the queue's request.
  assign deliver         = rdy_in && !_clear && (state == HOLD) && _InstFetcher_need_inst;
  assign _inst_ready_out = deliver;
  assign _inst_out       = deliver ? word_buf : 32'd0;
  assign _inst_addr      = deliver ? 32'(pc) : 32'd0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      pc         <= ADDR_WIDTH'(RESET_PC);
      byte_cnt   <= 3'd0;
      word_buf   <= 32'd0;
      pend_valid <= 1'b0;
      pend_idx   <= 2'd0;
      drop       <= 1'b0;
    end else if (rdy_in) begin
      pend_valid <= _mem_req && _mem_grant;
      pend_idx   <= byte_cnt[1:0];
      // A byte granted during a flush returns next cycle and must not land in the new word.
      drop       <= _clear;
      if (_clear) begin
        pc       <= ADDR_WIDTH'(_clear_pc);
        byte_cnt <= 3'd0;
        state    <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            byte_cnt <= 3'd0;
            state    <= FETCH;
          end
          FETCH: begin
            if (_mem_req && _mem_grant)
              byte_cnt <= byte_cnt + 3'd1;
            if (pend_valid && !drop) begin
              word_buf[{pend_idx, 3'b000} +: 8] <= _mem_din;
              if (pend_idx == 2'd3)
                state <= HOLD;
            end
          end
          HOLD: begin
            if (_InstFetcher_need_inst) begin
              pc       <= ADDR_WIDTH'(next_pc);
              byte_cnt <= 3'd0;
              state    <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed table-driven bench for inst_fetcher
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic [31:0] clear_pc;
  logic        need;
  logic [31:0] inst_out;
  logic        inst_ready;
  logic [31:0] inst_addr;
  logic        mem_req;
  logic [31:0] mem_a;
  logic        grant;
  logic [7:0]  din;

  logic [7:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] next;
  } vec_t;

  vec_t vecs [7];

  inst_fetcher dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    ._clear                 (clear),
    ._clear_pc              (clear_pc),
    ._InstFetcher_need_inst (need),
    ._inst_out              (inst_out),
    ._inst_ready_out        (inst_ready),
    ._inst_addr             (inst_addr),
    ._mem_req               (mem_req),
    ._mem_a                 (mem_a),
    ._mem_grant             (grant),
    ._mem_din               (din)
  );

  always #5 clk_in = ~clk_in;

  // Memory answers the cycle after a grant and otherwise holds its output.
  always @(posedge clk_in) begin
    if (mem_req && grant) din <= mem[mem_a[8:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[(a[8:0] + 9'(k))] = w[8*k +: 8];
  endtask

  task automatic wait_strobe(output logic found, output logic [31:0] w, output logic [31:0] a);
    found = 1'b0; w = '0; a = '0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk_in); #1;
      if (inst_ready) begin found = 1'b1; w = inst_out; a = inst_addr; end
    end
  endtask

  task automatic wait_req(output logic found, output logic [31:0] a);
    found = 1'b0; a = '0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk_in); #1;
      if (mem_req) begin found = 1'b1; a = mem_a; end
    end
  endtask

  task automatic do_clear(input logic [31:0] pc);
    @(negedge clk_in); clear = 1'b1; clear_pc = pc; #1;
    check("strobe in clear cycle", 32'(inst_ready), 32'd0);
    @(negedge clk_in); clear = 1'b0; #1;
  endtask

  task automatic count_grants(input int n);
    int got;
    got = 0;
    for (int c = 0; c < 30 && got < n; c++) begin
      if (c > 0) begin @(negedge clk_in); #1; end
      if (mem_req && grant) got++;
    end
    check("grant count reached", 32'(got), 32'(n));
  endtask

  logic        f;
  logic [31:0] w, a;
  logic [31:0] trace [4];
  int          ntr;

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h0080_006F, 32'h0000_0018};
    vecs[1] = '{32'h0000_0020, 32'hFE00_0EE3, 32'h0000_001C};
    vecs[2] = '{32'h0000_0040, 32'hFF1F_F06F, 32'h0000_0030};
    vecs[3] = '{32'h0000_0080, 32'h0000_1863, 32'h0000_0090};
    vecs[4] = '{32'h0000_0050, 32'h0000_0017, 32'h0000_0054};
    vecs[5] = '{32'h0000_0060, 32'h0000_8067, 32'h0000_0064};
    vecs[6] = '{32'hFFFF_FFF8, 32'h0080_006F, 32'h0000_0000};

    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    put_word(32'h0, 32'h0000_0013);

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; clear_pc = '0; need = 1'b1; grant = 1'b1;
    repeat (3) @(negedge clk_in);
    clear = 1'b1; clear_pc = 32'h0000_0100; #1;
    @(posedge clk_in); @(negedge clk_in); #1;
    check("reset ready", 32'(inst_ready), 32'd0);
    check("reset inst", inst_out, 32'd0);
    check("reset addr", inst_addr, 32'd0);
    check("reset req", 32'(mem_req), 32'd0);
    check("reset mem_a", mem_a, 32'd0);

    @(negedge clk_in); rst_in = 1'b0; clear = 1'b0; #1;
    check("idle no req", 32'(mem_req), 32'd0);
    ntr = 0; f = 1'b0;
    for (int n = 0; n < 40 && !f; n++) begin
      @(negedge clk_in); #1;
      if (inst_ready) begin f = 1'b1; w = inst_out; a = inst_addr; end
      else if (mem_req && grant && ntr < 4) begin trace[ntr] = mem_a; ntr++; end
    end
    check("first word grants", 32'(ntr), 32'd4);
    for (int k = 0; k < 4; k++) check("first word mem_a", trace[k], 32'(k));
    check("first strobe", 32'(f), 32'd1);
    check("first inst", w, 32'h0000_0013);
    check("first addr", a, 32'h0);
    wait_req(f, a);
    check("first next mem_a", a, 32'h4);

    for (int i = 0; i < 7; i++) begin
      put_word(vecs[i].pc, vecs[i].word);
      do_clear(vecs[i].pc);
      check("vec first mem_a", mem_a, vecs[i].pc);
      wait_strobe(f, w, a);
      check("vec strobe", 32'(f), 32'd1);
      check("vec inst", w, vecs[i].word);
      check("vec addr", a, vecs[i].pc);
      wait_req(f, a);
      check("vec next pc", a, vecs[i].next);
    end

    put_word(32'h0C0, 32'hFFFF_FFFF);
    put_word(32'h100, 32'h1234_5037);
    for (int ng = 2; ng <= 3; ng++) begin
      do_clear(32'h0C0);
      count_grants(ng);
      do_clear(32'h100);
      check("flush mem_a", mem_a, 32'h100);
      wait_strobe(f, w, a);
      check("flush strobe", 32'(f), 32'd1);
      check("flush inst", w, 32'h1234_5037);
      check("flush addr", a, 32'h100);
      wait_req(f, a);
      check("flush next pc", a, 32'h104);
    end

    put_word(32'h140, 32'h00A0_0093);
    @(negedge clk_in); clear = 1'b1; clear_pc = 32'h140; need = 1'b0; #1;
    @(negedge clk_in); clear = 1'b0; #1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_in); #1;
      check("hold no strobe", 32'(inst_ready), 32'd0);
      if (n >= 10) check("hold no req", 32'(mem_req), 32'd0);
    end
    @(negedge clk_in); need = 1'b1; #1;
    check("hold strobe", 32'(inst_ready), 32'd1);
    check("hold inst", inst_out, 32'h00A0_0093);
    check("hold addr", inst_addr, 32'h140);
    @(negedge clk_in); #1;
    check("hold single strobe", 32'(inst_ready), 32'd0);
    check("hold next mem_a", mem_a, 32'h144);

    put_word(32'h180, 32'hA5C3_E10F);
    do_clear(32'h180);
    count_grants(2);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_in); rdy_in = 1'b0; grant = n[0]; #1;
      check("frozen req", 32'(mem_req), 32'd0);
      check("frozen strobe", 32'(inst_ready), 32'd0);
    end
    @(negedge clk_in); rdy_in = 1'b1; grant = 1'b1; #1;
    check("resume req", 32'(mem_req), 32'd1);
    check("resume mem_a", mem_a, 32'h182);
    wait_strobe(f, w, a);
    check("resume strobe", 32'(f), 32'd1);
    check("resume inst", w, 32'hA5C3_E10F);
    check("resume addr", a, 32'h180);
    wait_req(f, a);
    check("resume next pc", a, 32'h184);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
